// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared types and constants for the CAM allocation controller
//               and its attached CAM: command encoding, controller state
//               encoding and the key width.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    // Width of keys stored in and looked up from the CAM
    localparam int CAM_KEY_W = 32;

    // CAM command: READ performs a match, WRITE stores a key at an index
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } command_t;

    // Controller sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_CHECK  = 3'd2,
        ST_INSERT = 3'd3,
        ST_RESP   = 3'd4
    } ctrl_state_t;

endpackage : cam_pkg
`default_nettype wire

// File: rtl/cam_free_slot_finder.sv
`default_nettype none
// ============================================================================
// Module      : cam_free_slot_finder
// Description : Combinational priority encoder. Given the map of occupied
//               CAM slots, reports whether any slot is free and the lowest
//               free index.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_free_slot_finder #(
    parameter  int SIZE = 8,
    localparam int IDXW = $clog2(SIZE)
) (
    input  logic [SIZE-1:0] i_valid_map,
    output logic            o_found,
    output logic [IDXW-1:0] o_idx
);

    // Scan from the top down so the lowest free index is the last one written
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (!i_valid_map[i]) begin
                o_found = 1'b1;
                o_idx   = IDXW'(i);
            end
        end
    end

endmodule : cam_free_slot_finder
`default_nettype wire

// File: rtl/cam_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cam_alloc_ctrl
// Description : Lookup-or-insert sequencer in front of a SIZE-entry CAM.
//               Accepts one key at a time, issues a CAM READ, and on a miss
//               with insert requested allocates a slot (lowest free, else a
//               round-robin victim) and issues a CAM WRITE. Returns index,
//               hit and evict flags on a valid/ready response channel.
//               Optional macro CAM_CTRL_STATS_EN adds saturating hit, miss
//               and evict counters (stat_hits, stat_misses, stat_evicts).
// Revision    : 1.0 - initial release
// ============================================================================
module cam_alloc_ctrl
    import cam_pkg::*;
#(
    parameter  int SIZE = 8,
    localparam int IDXW = $clog2(SIZE)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CAM_KEY_W-1:0] req_key,
    input  logic                 req_insert,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDXW-1:0]      resp_idx,
    output logic                 resp_hit,
    output logic                 resp_evict,
    output logic [IDXW:0]        occupancy,
    output logic                 cam_enable,
    output command_t             cam_command,
    output logic [CAM_KEY_W-1:0] cam_data,
    output logic [IDXW-1:0]      cam_write_idx,
    input  logic [IDXW-1:0]      cam_read_idx,
    input  logic                 cam_hit
`ifdef CAM_CTRL_STATS_EN
    ,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_misses,
    output logic [31:0]          stat_evicts
`endif
);

    localparam logic [IDXW:0] c_occ_max = (IDXW + 1)'(SIZE);

    ctrl_state_t            r_state_q,      w_state_d;
    logic [CAM_KEY_W-1:0]   r_key_q,        w_key_d;
    logic                   r_insert_q,     w_insert_d;
    logic                   r_req_ready_q,  w_req_ready_d;
    logic                   r_resp_valid_q, w_resp_valid_d;
    logic [IDXW-1:0]        r_resp_idx_q,   w_resp_idx_d;
    logic                   r_resp_hit_q,   w_resp_hit_d;
    logic                   r_resp_evict_q, w_resp_evict_d;
    logic [IDXW:0]          r_occ_q,        w_occ_d;
    logic [SIZE-1:0]        r_valid_map_q,  w_valid_map_d;
    logic [IDXW-1:0]        r_victim_q,     w_victim_d;
    logic                   r_cam_en_q,     w_cam_en_d;
    command_t               r_cam_cmd_q,    w_cam_cmd_d;
    logic [IDXW-1:0]        r_cam_widx_q,   w_cam_widx_d;
    logic                   r_ins_evict_q,  w_ins_evict_d;

    logic                   w_free_found;
    logic [IDXW-1:0]        w_free_idx;

    cam_free_slot_finder #(
        .SIZE        (SIZE)
    ) u_free_slot_finder (
        .i_valid_map (r_valid_map_q),
        .o_found     (w_free_found),
        .o_idx       (w_free_idx)
    );

    // Next-state and next-output logic; CAM strobes are one-cycle pulses
    // registered on entry to LOOKUP and INSERT.
    always_comb begin
        w_state_d      = r_state_q;
        w_key_d        = r_key_q;
        w_insert_d     = r_insert_q;
        w_req_ready_d  = r_req_ready_q;
        w_resp_valid_d = r_resp_valid_q;
        w_resp_idx_d   = r_resp_idx_q;
        w_resp_hit_d   = r_resp_hit_q;
        w_resp_evict_d = r_resp_evict_q;
        w_occ_d        = r_occ_q;
        w_valid_map_d  = r_valid_map_q;
        w_victim_d     = r_victim_q;
        w_cam_en_d     = 1'b0;
        w_cam_cmd_d    = READ;
        w_cam_widx_d   = r_cam_widx_q;
        w_ins_evict_d  = r_ins_evict_q;

        case (r_state_q)
            ST_IDLE: begin
                if (req_valid && r_req_ready_q) begin
                    w_key_d       = req_key;
                    w_insert_d    = req_insert;
                    w_req_ready_d = 1'b0;
                    w_cam_en_d    = 1'b1;
                    w_cam_cmd_d   = READ;
                    w_state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                w_state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (cam_hit) begin
                    w_resp_valid_d = 1'b1;
                    w_resp_hit_d   = 1'b1;
                    w_resp_idx_d   = cam_read_idx;
                    w_resp_evict_d = 1'b0;
                    w_state_d      = ST_RESP;
                end else if (!r_insert_q) begin
                    w_resp_valid_d = 1'b1;
                    w_resp_hit_d   = 1'b0;
                    w_resp_idx_d   = '0;
                    w_resp_evict_d = 1'b0;
                    w_state_d      = ST_RESP;
                end else begin
                    // Slot choice is frozen here so the WRITE and the map
                    // update both use the same index.
                    w_cam_en_d    = 1'b1;
                    w_cam_cmd_d   = WRITE;
                    w_cam_widx_d  = w_free_found ? w_free_idx : r_victim_q;
                    w_ins_evict_d = !w_free_found;
                    w_state_d     = ST_INSERT;
                end
            end
            ST_INSERT: begin
                w_valid_map_d[r_cam_widx_q] = 1'b1;
                if (r_ins_evict_q) begin
                    w_victim_d = r_victim_q + IDXW'(1);
                end else if (r_occ_q != c_occ_max) begin
                    w_occ_d = r_occ_q + (IDXW + 1)'(1);
                end
                w_resp_valid_d = 1'b1;
                w_resp_hit_d   = 1'b0;
                w_resp_idx_d   = r_cam_widx_q;
                w_resp_evict_d = r_ins_evict_q;
                w_state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_resp_valid_d = 1'b0;
                    w_req_ready_d  = 1'b1;
                    w_state_d      = ST_IDLE;
                end
            end
            default: begin
                w_resp_valid_d = 1'b0;
                w_req_ready_d  = 1'b1;
                w_state_d      = ST_IDLE;
            end
        endcase
    end

    // Controller state register; reset abandons any in-flight CAM write
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q      <= ST_IDLE;
            r_key_q        <= '0;
            r_insert_q     <= 1'b0;
            r_req_ready_q  <= 1'b1;
            r_resp_valid_q <= 1'b0;
            r_resp_idx_q   <= '0;
            r_resp_hit_q   <= 1'b0;
            r_resp_evict_q <= 1'b0;
            r_occ_q        <= '0;
            r_valid_map_q  <= '0;
            r_victim_q     <= '0;
            r_cam_en_q     <= 1'b0;
            r_cam_cmd_q    <= READ;
            r_cam_widx_q   <= '0;
            r_ins_evict_q  <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_key_q        <= w_key_d;
            r_insert_q     <= w_insert_d;
            r_req_ready_q  <= w_req_ready_d;
            r_resp_valid_q <= w_resp_valid_d;
            r_resp_idx_q   <= w_resp_idx_d;
            r_resp_hit_q   <= w_resp_hit_d;
            r_resp_evict_q <= w_resp_evict_d;
            r_occ_q        <= w_occ_d;
            r_valid_map_q  <= w_valid_map_d;
            r_victim_q     <= w_victim_d;
            r_cam_en_q     <= w_cam_en_d;
            r_cam_cmd_q    <= w_cam_cmd_d;
            r_cam_widx_q   <= w_cam_widx_d;
            r_ins_evict_q  <= w_ins_evict_d;
        end
    end

    assign req_ready     = r_req_ready_q;
    assign resp_valid    = r_resp_valid_q;
    assign resp_idx      = r_resp_idx_q;
    assign resp_hit      = r_resp_hit_q;
    assign resp_evict    = r_resp_evict_q;
    assign occupancy     = r_occ_q;
    assign cam_enable    = r_cam_en_q;
    assign cam_command   = r_cam_cmd_q;
    assign cam_data      = r_key_q;
    assign cam_write_idx = r_cam_widx_q;

`ifdef CAM_CTRL_STATS_EN
    logic [31:0] r_stat_hits_q,   w_stat_hits_d;
    logic [31:0] r_stat_misses_q, w_stat_misses_d;
    logic [31:0] r_stat_evicts_q, w_stat_evicts_d;
    logic        w_resp_fire;

    assign w_resp_fire = r_resp_valid_q && resp_ready;

    // Saturating per-kind counters, stepped once per completed response
    always_comb begin
        w_stat_hits_d   = r_stat_hits_q;
        w_stat_misses_d = r_stat_misses_q;
        w_stat_evicts_d = r_stat_evicts_q;
        if (w_resp_fire) begin
            if (r_resp_hit_q && (r_stat_hits_q != '1)) begin
                w_stat_hits_d = r_stat_hits_q + 32'd1;
            end
            if (!r_resp_hit_q && (r_stat_misses_q != '1)) begin
                w_stat_misses_d = r_stat_misses_q + 32'd1;
            end
            if (r_resp_evict_q && (r_stat_evicts_q != '1)) begin
                w_stat_evicts_d = r_stat_evicts_q + 32'd1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_hits_q   <= '0;
            r_stat_misses_q <= '0;
            r_stat_evicts_q <= '0;
        end else begin
            r_stat_hits_q   <= w_stat_hits_d;
            r_stat_misses_q <= w_stat_misses_d;
            r_stat_evicts_q <= w_stat_evicts_d;
        end
    end

    assign stat_hits   = r_stat_hits_q;
    assign stat_misses = r_stat_misses_q;
    assign stat_evicts = r_stat_evicts_q;
`endif

endmodule : cam_alloc_ctrl
`default_nettype wire

// File: tb/tb_cam_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_alloc_ctrl
// Description : Self-checking bench for cam_alloc_ctrl with a behavioural
//               8-entry CAM attached. Directed scenarios followed by a
//               randomized run compared against a table-level reference.
//               Latency is counted in cycles including the accept cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_alloc_ctrl;
    import cam_pkg::*;

    localparam int SIZE = 8;
    localparam int IDXW = 3;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [31:0]          req_key;
    logic                 req_insert;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDXW-1:0]      resp_idx;
    logic                 resp_hit;
    logic                 resp_evict;
    logic [IDXW:0]        occupancy;
    logic                 cam_enable;
    command_t             cam_command;
    logic [31:0]          cam_data;
    logic [IDXW-1:0]      cam_write_idx;
    logic [IDXW-1:0]      cam_read_idx;
    logic                 cam_hit;
`ifdef CAM_CTRL_STATS_EN
    logic [31:0]          stat_hits;
    logic [31:0]          stat_misses;
    logic [31:0]          stat_evicts;
`endif

    int checks = 0;
    int errors = 0;
    int write_cnt = 0;

    always #5 clock = ~clock;

    cam_alloc_ctrl #(.SIZE(SIZE)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_key       (req_key),
        .req_insert    (req_insert),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_idx      (resp_idx),
        .resp_hit      (resp_hit),
        .resp_evict    (resp_evict),
        .occupancy     (occupancy),
        .cam_enable    (cam_enable),
        .cam_command   (cam_command),
        .cam_data      (cam_data),
        .cam_write_idx (cam_write_idx),
        .cam_read_idx  (cam_read_idx),
        .cam_hit       (cam_hit)
`ifdef CAM_CTRL_STATS_EN
        ,
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses),
        .stat_evicts   (stat_evicts)
`endif
    );

    // ---------------- behavioural CAM (sync reset, registered match) -------
    logic [31:0] cam_mem [SIZE];
    logic        cam_vld [SIZE];

    function automatic logic cam_found(input logic [31:0] k);
        for (int i = 0; i < SIZE; i++) if (cam_vld[i] && cam_mem[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [IDXW-1:0] cam_pos(input logic [31:0] k);
        for (int i = 0; i < SIZE; i++) if (cam_vld[i] && cam_mem[i] == k) return IDXW'(i);
        return '0;
    endfunction

    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < SIZE; i++) begin
                cam_vld[i] <= 1'b0;
                cam_mem[i] <= '0;
            end
            cam_hit      <= 1'b0;
            cam_read_idx <= '0;
        end else if (cam_enable) begin
            if (cam_command == WRITE) begin
                cam_mem[cam_write_idx] <= cam_data;
                cam_vld[cam_write_idx] <= 1'b1;
                write_cnt <= write_cnt + 1;
            end else begin
                cam_hit      <= cam_found(cam_data);
                cam_read_idx <= cam_pos(cam_data);
            end
        end
    end

    // ---------------- reference model: table of keys --------------------
    logic [31:0] m_key [SIZE];
    bit          m_vld [SIZE];
    int          m_victim, m_occ, m_hits, m_misses, m_evicts;

    task automatic model_reset();
        for (int i = 0; i < SIZE; i++) begin m_vld[i] = 0; m_key[i] = '0; end
        m_victim = 0; m_occ = 0; m_hits = 0; m_misses = 0; m_evicts = 0;
    endtask

    task automatic model_req(input logic [31:0] key, input logic ins, output int e_cyc,
                             output logic [IDXW-1:0] e_idx, output logic e_hit,
                             output logic e_evict, output int e_occ);
        int f;
        f = -1;
        for (int i = 0; i < SIZE; i++) if (m_vld[i] && m_key[i] == key) f = i;
        e_evict = 1'b0;
        if (f >= 0) begin
            e_hit = 1'b1; e_idx = IDXW'(f); e_cyc = 3;
        end else if (!ins) begin
            e_hit = 1'b0; e_idx = '0; e_cyc = 3;
        end else begin
            e_hit = 1'b0; e_cyc = 4;
            for (int i = SIZE - 1; i >= 0; i--) if (!m_vld[i]) f = i;
            if (f < 0) begin
                f = m_victim; m_victim = (m_victim + 1) % SIZE; e_evict = 1'b1;
            end else begin
                m_occ++;
            end
            m_key[f] = key; m_vld[f] = 1; e_idx = IDXW'(f);
        end
        e_occ = m_occ;
        if (e_hit) m_hits++; else m_misses++;
        if (e_evict) m_evicts++;
    endtask

    // ---------------- transaction driver ---------------------------------
    // cyc = cycles from accept (inclusive) to resp_valid, -1 on timeout.
    // back_idle = resp_valid low and req_ready high right after handshake.
    task automatic xact(input logic [31:0] key, input logic ins, input int rr_delay,
                        output int cyc, output logic [IDXW-1:0] idx, output logic hit,
                        output logic evict, output int occ, output logic back_idle);
        @(negedge clock);
        req_valid = 1'b1; req_key = key; req_insert = ins; resp_ready = (rr_delay == 0);
        @(posedge clock);
        #1 req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            @(posedge clock); #1; cyc++;
        end
        if (!resp_valid) begin
            cyc = -1; idx = 'x; hit = 1'bx; evict = 1'bx; occ = -1; back_idle = 1'b0;
            resp_ready = 1'b0;
            return;
        end
        idx = resp_idx; hit = resp_hit; evict = resp_evict; occ = int'(occupancy);
        if (rr_delay > 0) begin
            repeat (rr_delay) @(posedge clock);
            @(negedge clock); resp_ready = 1'b1;
        end
        @(posedge clock); #1;
        back_idle = !resp_valid && req_ready;
        resp_ready = 1'b0;
    endtask

    // ---------------- scenarios ------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_key = '0; req_insert = 1'b0; resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if ({resp_idx, resp_hit, resp_evict} !== '0) begin errors++; $display("FAIL reset_resp_fields: got idx=%0d hit=%b evict=%b expected 0", resp_idx, resp_hit, resp_evict); end
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++; if (cam_enable !== 1'b0) begin errors++; $display("FAIL reset_cam_enable: got %b expected 0", cam_enable); end
        @(negedge clock) reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_lookup_miss();
        int cyc, occ; logic [IDXW-1:0] idx; logic hit, ev, bi;
        xact(32'hDEAD_BEEF, 1'b0, 0, cyc, idx, hit, ev, occ, bi);
        checks++; if (cyc != 3) begin errors++; $display("FAIL miss_latency: got %0d expected 3", cyc); end
        checks++; if ({hit, ev, idx} !== '0) begin errors++; $display("FAIL miss_fields: got hit=%b evict=%b idx=%0d expected 0/0/0", hit, ev, idx); end
        checks++; if (occ != 0) begin errors++; $display("FAIL miss_occupancy: got %0d expected 0", occ); end
        checks++; if (bi !== 1'b1) begin errors++; $display("FAIL miss_back_idle: got %b expected 1", bi); end
    endtask

    task automatic test_insert();
        int cyc, occ; logic [IDXW-1:0] idx; logic hit, ev, bi;
        logic [31:0] keys [3] = '{32'h11, 32'h22, 32'h33};
        for (int k = 0; k < 3; k++) begin
            xact(keys[k], 1'b1, 0, cyc, idx, hit, ev, occ, bi);
            checks++; if (cyc != 4) begin errors++; $display("FAIL insert%0d_latency: got %0d expected 4", k, cyc); end
            checks++; if (idx !== IDXW'(k) || hit !== 1'b0 || ev !== 1'b0) begin errors++; $display("FAIL insert%0d_fields: got idx=%0d hit=%b evict=%b expected idx=%0d 0 0", k, idx, hit, ev, k); end
            checks++; if (occ != k + 1) begin errors++; $display("FAIL insert%0d_occupancy: got %0d expected %0d", k, occ, k + 1); end
        end
        xact(32'h22, 1'b0, 0, cyc, idx, hit, ev, occ, bi);
        checks++; if (cyc != 3 || hit !== 1'b1 || idx !== 3'd1) begin errors++; $display("FAIL lookup_hit: got cyc=%0d hit=%b idx=%0d expected 3 1 1", cyc, hit, idx); end
    endtask

    task automatic test_reinsert();
        int cyc, occ, w0; logic [IDXW-1:0] idx; logic hit, ev, bi;
        w0 = write_cnt;
        xact(32'h22, 1'b1, 0, cyc, idx, hit, ev, occ, bi);
        checks++; if (cyc != 3 || hit !== 1'b1 || idx !== 3'd1 || ev !== 1'b0) begin errors++; $display("FAIL reinsert_fields: got cyc=%0d hit=%b idx=%0d evict=%b expected 3 1 1 0", cyc, hit, idx, ev); end
        checks++; if (write_cnt != w0) begin errors++; $display("FAIL reinsert_no_write: got %0d writes expected 0", write_cnt - w0); end
        checks++; if (occ != 3) begin errors++; $display("FAIL reinsert_occupancy: got %0d expected 3", occ); end
    endtask

    task automatic test_evict();
        int cyc, occ; logic [IDXW-1:0] idx; logic hit, ev, bi;
        for (int k = 3; k < SIZE; k++) begin
            xact(32'h40 + 32'(k), 1'b1, 0, cyc, idx, hit, ev, occ, bi);
            checks++; if (idx !== IDXW'(k) || ev !== 1'b0 || occ != k + 1) begin errors++; $display("FAIL fill%0d: got idx=%0d evict=%b occ=%0d expected %0d 0 %0d", k, idx, ev, occ, k, k + 1); end
        end
        for (int k = 0; k < 2; k++) begin
            xact(32'hA0 + 32'(k), 1'b1, 0, cyc, idx, hit, ev, occ, bi);
            checks++; if (cyc != 4 || idx !== IDXW'(k) || ev !== 1'b1 || hit !== 1'b0 || occ != SIZE) begin errors++; $display("FAIL evict%0d: got cyc=%0d idx=%0d evict=%b hit=%b occ=%0d expected 4 %0d 1 0 8", k, cyc, idx, ev, hit, occ, k); end
        end
        xact(32'h11, 1'b0, 0, cyc, idx, hit, ev, occ, bi);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL evicted_key_gone: got hit=%b expected 0", hit); end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clock);
        req_valid = 1'b1; req_key = 32'hA0; req_insert = 1'b0; resp_ready = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 10) begin @(posedge clock); #1; n++; end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_timeout: got resp_valid=%b expected 1", resp_valid); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_idx !== 3'd0 || resp_hit !== 1'b1 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b idx=%0d hit=%b req_ready=%b expected 1 0 1 0", k, resp_valid, resp_idx, resp_hit, req_ready);
            end
        end
        @(negedge clock) resp_ready = 1'b1;
        @(posedge clock); #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b req_ready=%b expected 0 1", resp_valid, req_ready); end
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clock);
        req_valid = 1'b1; req_key = 32'hBB; req_insert = 1'b1; resp_ready = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        n = 0;
        while (!(cam_enable === 1'b1 && cam_command == WRITE) && n < 10) begin @(posedge clock); #1; n++; end
        checks++; if (n >= 10) begin errors++; $display("FAIL rst_mid_reach_insert: got no WRITE within %0d cycles expected one", n); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || cam_enable !== 1'b0 || occupancy !== '0 ||
            {resp_idx, resp_hit, resp_evict} !== '0 || cam_command != READ) begin
            errors++;
            $display("FAIL rst_mid_outputs: got req_ready=%b resp_valid=%b cam_en=%b occ=%0d idx=%0d hit=%b evict=%b expected 1 0 0 0 0 0 0",
                     req_ready, resp_valid, cam_enable, occupancy, resp_idx, resp_hit, resp_evict);
        end
`ifdef CAM_CTRL_STATS_EN
        checks++; if ({stat_hits, stat_misses, stat_evicts} !== '0) begin errors++; $display("FAIL rst_mid_stats: got %0d %0d %0d expected 0 0 0", stat_hits, stat_misses, stat_evicts); end
`endif
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int cyc, occ, e_cyc, e_occ, w0;
        logic [IDXW-1:0] idx, e_idx; logic hit, ev, bi, e_hit, e_ev, ins;
        logic [31:0] key;
        for (int t = 0; t < 150; t++) begin
            key = 32'h1000 + 32'($urandom_range(0, 11));
            ins = 1'($urandom_range(0, 1));
            w0  = write_cnt;
            model_req(key, ins, e_cyc, e_idx, e_hit, e_ev, e_occ);
            xact(key, ins, int'($urandom_range(0, 2)), cyc, idx, hit, ev, occ, bi);
            checks++;
            if (cyc != e_cyc || idx !== e_idx || hit !== e_hit || ev !== e_ev || occ != e_occ || bi !== 1'b1 ||
                (write_cnt - w0) != ((e_cyc == 4) ? 1 : 0)) begin
                errors++;
                $display("FAIL rand%0d key=%h ins=%b: got cyc=%0d idx=%0d hit=%b ev=%b occ=%0d idle=%b wr=%0d expected %0d %0d %b %b %0d 1 %0d",
                         t, key, ins, cyc, idx, hit, ev, occ, bi, write_cnt - w0, e_cyc, e_idx, e_hit, e_ev, e_occ, (e_cyc == 4) ? 1 : 0);
            end
        end
`ifdef CAM_CTRL_STATS_EN
        checks++;
        if (stat_hits != 32'(m_hits) || stat_misses != 32'(m_misses) || stat_evicts != 32'(m_evicts)) begin
            errors++;
            $display("FAIL rand_stats: got %0d %0d %0d expected %0d %0d %0d", stat_hits, stat_misses, stat_evicts, m_hits, m_misses, m_evicts);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lookup_miss();
        test_insert();
        test_reinsert();
        test_evict();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion by 300000 ns expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_cam_alloc_ctrl
`default_nettype wire
